// File: rtl/mp_add_sequencer_if.sv
// mp_add_sequencer_if
//   Request/result bundle between a requester and mp_add_sequencer.
//   master : requester side (drives start/sub/a_in/b_in/cin, reads results)
//   slave  : sequencer side (reads the request, drives busy/done/result/cout/overflow)
interface mp_add_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, a_in, b_in, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a_in, b_in, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer
//   Multi-precision add/subtract built around one shared 8-bit ripple-carry
//   adder. One byte is processed per clock, LSB first; the inter-byte carry
//   lives in a register.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : slave side of mp_add_sequencer_if (start/sub/a_in/b_in/cin in,
//            busy/done/result/cout/overflow out)

// 8-bit ripple-carry adder used as the shared datapath.
module ripple_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[8];
endmodule

module mp_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  mp_add_sequencer_if.slave  bus
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q,    state_d;
  logic [IDXW-1:0] idx_q,      idx_d;
  logic [W-1:0]    a_q,        a_d;
  logic [W-1:0]    b_q,        b_d;       // B already inverted for subtract
  logic            carry_q,    carry_d;
  logic [W-1:0]    result_q,   result_d;
  logic            cout_q,     cout_d;
  logic            overflow_q, overflow_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;

  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;

  assign add_a = a_q[8*idx_q +: 8];
  assign add_b = b_q[8*idx_q +: 8];

  ripple_carry_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_d      = bus.a_in;
          // Subtract is A + ~B + 1, so the +1 enters through the carry.
          b_d      = bus.sub ? ~bus.b_in : bus.b_in;
          carry_d  = bus.sub ? 1'b1 : bus.cin;
          result_d = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        result_d[8*idx_q +: 8] = add_sum;
        carry_d                = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d     = add_cout;
          // Signed overflow: operands share a sign that the result lacks.
          overflow_d = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
          state_d    = DONE;
          done_d     = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb_mp_add_sequencer
//   Table-driven and scoreboarded bench for mp_add_sequencer with NBYTES=4.
module tb_mp_add_sequencer;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mp_add_sequencer_if #(.NBYTES(NB)) bus ();

  mp_add_sequencer #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_result;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_pulses = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected record.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_pulses++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", bus.result, e.result);
        check("sb_cout", {31'd0, bus.cout}, {31'd0, e.cout});
        check("sb_overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
        $display("done: result=0x%08h cout=%0b ovf=%0b (exp 0x%08h %0b %0b)",
                 bus.result, bus.cout, bus.overflow, e.result, e.cout, e.ovf);
      end
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.cin   = 1'b0;
  endtask

  // Drive one operation, push its expectation, check latency, pulse width
  // and result stability.
  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = v.sub;
    bus.a_in  = v.a;
    bus.b_in  = v.b;
    bus.cin   = v.cin;
    e.result  = v.exp_result;
    e.cout    = v.exp_cout;
    e.ovf     = v.exp_ovf;
    sb_q.push_back(e);
    @(posedge clk);  // accept edge
    #1;
    bus.start = 1'b0;
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
    check({tag, "_busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // done is first seen after the NBYTES-th edge following accept.
    check({tag, "_latency"}, lat, NB);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_result_held"}, bus.result, v.exp_result);
    $display("%s: sub=%0b a=0x%08h b=0x%08h cin=%0b -> 0x%08h latency=%0d",
             tag, v.sub, v.a, v.b, v.cin, bus.result, lat);
  endtask

  vec_t vecs[9];

  initial begin
    vec_t v;
    int   pulses_before;

    vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_cout", {31'd0, bus.cout}, 32'd0);
    check("reset_overflow", {31'd0, bus.overflow}, 32'd0);

    // start together with reset: reset wins.
    bus.start = 1'b1;
    bus.a_in  = 32'h1;
    bus.b_in  = 32'h1;
    @(posedge clk);
    #1;
    check("rst_beats_start_busy", {31'd0, bus.busy}, 32'd0);
    $display("start during reset: busy=%0b", bus.busy);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Re-pulsed start during RUN and DONE is ignored.
    pulses_before = done_pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.a_in  = 32'h1;
    bus.b_in  = 32'h2;
    bus.cin   = 1'b0;
    sb_q.push_back('{32'h00000003, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    bus.a_in = 32'h12345678;
    bus.b_in = 32'h11111111;
    for (int c = 0; c < NB + 1; c++) begin
      check($sformatf("busy_cont_%0d", c), {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check("busy_ignore_idle", {31'd0, bus.busy}, 32'd0);
    check("busy_ignore_result", bus.result, 32'h00000003);
    repeat (2) @(posedge clk);
    #1;
    check("busy_ignore_one_pulse", done_pulses - pulses_before, 32'd1);
    $display("start-while-busy: result=0x%08h pulses=%0d", bus.result, done_pulses - pulses_before);
    idle_inputs();

    // Reset during the second RUN cycle aborts the operation.
    pulses_before = done_pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 32'h0000FFFF;
    bus.b_in  = 32'h00000001;
    @(posedge clk);  // accept
    #1;
    bus.start = 1'b0;
    @(posedge clk);  // first RUN edge
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_pulse", done_pulses - pulses_before, 32'd0);
    $display("abort: busy=%0b result=0x%08h pulses=%0d", bus.busy, bus.result, done_pulses - pulses_before);

    v = '{1'b0, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0};
    run_op(v, "after_abort");

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "timeout");
  end
endmodule
